// File: rtl/pkg_windowAlignment.sv
// Geometry shared with the windowAlignment shift stage: block word layout and
// line-buffer row/block address widths.
package pkg_windowAlignment;
   localparam int WORDS       = 4;
   localparam int WORD_SIZE   = 8;
   localparam int INDEX_WIDTH = 4;
   localparam int BLOCK_WIDTH = 4;
endpackage

// File: rtl/pkg_window_sequencer.sv
// Sequencer state encoding, drain length and default geometry.
package pkg_window_sequencer;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Matches the windowAlignment pipeline latency so frame_done marks the last write leaving it.
   localparam int DRAIN_CYCLES = 2;

   localparam int DEF_BLOCKS         = 8;
   localparam int DEF_ROWS_PER_FRAME = 480;
   localparam int DEF_DEPTH          = 16;
endpackage

// File: rtl/structs.sv
// Write-port bundle consumed by windowAlignment.waIn.
package structs;
   import pkg_windowAlignment::*;

   typedef struct packed {
      logic                            we;
      logic [INDEX_WIDTH-1:0]          waddrY;
      logic [BLOCK_WIDTH-1:0]          waddrBlock;
      logic [WORDS-1:0][WORD_SIZE-1:0] wdata;
   } struct_windowAlignment;
endpackage

// File: rtl/row_credit_counter.sv
// Saturating free-row credit counter; a simultaneous take and return cancel out.
module row_credit_counter #(
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       inc_i,
   input  logic                       dec_i,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && !dec_i && (count_q != FULL)) begin
         count_d = count_q + 1'b1;
      end else if (dec_i && !inc_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= FULL;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
endmodule

// File: rtl/window_write_sequencer.sv
// Write-side controller for the window line buffer: turns an accepted pixel-block
// stream into windowAlignment writes, tracking row/frame position and row credits.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | no frame in progress, waiting for frame_start
//   ST_FILL  | accepting blocks while row credits remain
//   ST_DRAIN | last write travelling through windowAlignment, then frame_done
module window_write_sequencer
   import pkg_windowAlignment::*;
   import structs::*;
   import pkg_window_sequencer::*;
#(
   parameter int BLOCKS         = DEF_BLOCKS,
   parameter int ROWS_PER_FRAME = DEF_ROWS_PER_FRAME,
   parameter int DEPTH          = DEF_DEPTH
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            frame_start,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [WORDS-1:0][WORD_SIZE-1:0] in_data,
   input  logic                            row_release,
   output struct_windowAlignment           wa,
   output logic                            row_done,
   output logic                            frame_done,
   output logic [$clog2(DEPTH+1)-1:0]      rows_free,
   output logic                            busy
);
   localparam int RCW = (ROWS_PER_FRAME > 1) ? $clog2(ROWS_PER_FRAME) : 1;
   localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [BLOCK_WIDTH-1:0] LAST_BLK    = BLOCK_WIDTH'(BLOCKS - 1);
   localparam logic [INDEX_WIDTH-1:0] LAST_ROWPTR = INDEX_WIDTH'(DEPTH - 1);
   localparam logic [RCW-1:0]         LAST_ROW    = RCW'(ROWS_PER_FRAME - 1);
   localparam logic [DCW-1:0]         DRAIN_LAST  = DCW'(DRAIN_CYCLES - 1);

   state_t                state_q, state_d;
   logic [BLOCK_WIDTH-1:0] blk_q, blk_d;
   logic [INDEX_WIDTH-1:0] rowptr_q, rowptr_d;
   logic [RCW-1:0]         rowcnt_q, rowcnt_d;
   logic [DCW-1:0]         drain_q, drain_d;
   struct_windowAlignment wa_q, wa_d;
   logic                  row_done_q, row_done_d;
   logic                  frame_done_q, frame_done_d;
   logic                  xfer;
   logic                  row_end;
   logic [$clog2(DEPTH+1)-1:0] credits;

   row_credit_counter #(.DEPTH(DEPTH)) u_credits (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (row_release),
      .dec_i   (row_end),
      .count_o (credits)
   );

   // Ready comes from registers only, so a frame_start cycle can never also take a beat.
   assign in_ready = (state_q == ST_FILL) && (credits != '0);
   assign xfer     = in_valid && in_ready;
   assign row_end  = xfer && (blk_q == LAST_BLK);

   always_comb begin
      state_d      = state_q;
      blk_d        = blk_q;
      rowptr_d     = rowptr_q;
      rowcnt_d     = rowcnt_q;
      drain_d      = drain_q;
      wa_d         = wa_q;
      wa_d.we      = 1'b0;
      row_done_d   = 1'b0;
      frame_done_d = 1'b0;

      if (xfer) begin
         wa_d.we         = 1'b1;
         wa_d.wdata      = in_data;
         wa_d.waddrBlock = blk_q;
         wa_d.waddrY     = rowptr_q;
         blk_d           = blk_q + 1'b1;
      end

      if (row_end) begin
         blk_d      = '0;
         rowptr_d   = (rowptr_q == LAST_ROWPTR) ? '0 : rowptr_q + 1'b1;
         rowcnt_d   = rowcnt_q + 1'b1;
         row_done_d = 1'b1;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (frame_start) begin
               state_d  = ST_FILL;
               blk_d    = '0;
               rowcnt_d = '0;
            end
         end
         ST_FILL: begin
            if (row_end && (rowcnt_q == LAST_ROW)) begin
               state_d = ST_DRAIN;
               drain_d = DRAIN_LAST;
            end
         end
         ST_DRAIN: begin
            if (drain_q == '0) begin
               state_d      = ST_IDLE;
               frame_done_d = 1'b1;
            end else begin
               drain_d = drain_q - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         blk_q        <= '0;
         rowptr_q     <= '0;
         rowcnt_q     <= '0;
         drain_q      <= '0;
         wa_q         <= '0;
         row_done_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         blk_q        <= blk_d;
         rowptr_q     <= rowptr_d;
         rowcnt_q     <= rowcnt_d;
         drain_q      <= drain_d;
         wa_q         <= wa_d;
         row_done_q   <= row_done_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign wa         = wa_q;
   assign row_done   = row_done_q;
   assign frame_done = frame_done_q;
   assign rows_free  = credits;
   assign busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_window_write_sequencer.sv
// Bench for window_write_sequencer: directed table, corner-case sequences and a
// randomized run against a transaction-count reference model.
module tb_window_write_sequencer;
   import pkg_windowAlignment::*;
   import structs::*;

   localparam int BLK   = 4;
   localparam int ROWS  = 6;
   localparam int DEP   = 4;
   localparam int TOTAL = BLK * ROWS;
   localparam int FW    = $clog2(DEP + 1);

   logic                            clk = 1'b0;
   logic                            rst = 1'b1;
   logic                            frame_start = 1'b0;
   logic                            in_valid = 1'b0;
   logic                            row_release = 1'b0;
   logic [WORDS-1:0][WORD_SIZE-1:0] in_data = '0;
   logic                            in_ready;
   logic                            row_done;
   logic                            frame_done;
   logic                            busy;
   logic [FW-1:0]                   rows_free;
   struct_windowAlignment           wa;

   always #5 clk = ~clk;

   window_write_sequencer #(
      .BLOCKS         (BLK),
      .ROWS_PER_FRAME (ROWS),
      .DEPTH          (DEP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .row_release (row_release),
      .wa          (wa),
      .row_done    (row_done),
      .frame_done  (frame_done),
      .rows_free   (rows_free),
      .busy        (busy)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: frame progress as transfer counts, write address by arithmetic.
   int          m_cyc        = 0;
   int          m_beats      = 0;
   int          m_rows_total = 0;
   int          m_credits    = DEP;
   int          m_drain_end  = -100;
   bit          m_fill       = 1'b0;
   bit          e_we         = 1'b0;
   bit          e_rd         = 1'b0;
   int          e_y          = 0;
   int          e_blk        = 0;
   logic [31:0] e_data       = '0;
   int          cnt_we = 0, cnt_rd = 0, cnt_fd = 0;

   typedef struct {
      bit fs; bit v; bit rel;
      bit we; int y; int blk; bit rd; bit fd; bit rdy; int free; bit bsy;
   } vec_t;
   vec_t tbl[11];

   function automatic bit m_ready();
      return m_fill && (m_credits > 0);
   endfunction

   function automatic bit m_busy();
      return m_fill || (m_cyc < m_drain_end);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic sync_check();
      @(negedge clk);
      chk("in_ready",   in_ready,      m_ready());
      chk("busy",       busy,          m_busy());
      chk("frame_done", frame_done,    (m_cyc == m_drain_end));
      chk("rows_free",  rows_free,     m_credits);
      chk("we",         wa.we,         e_we);
      chk("row_done",   row_done,      e_rd);
      chk("waddrBlock", wa.waddrBlock, e_blk);
      chk("waddrY",     wa.waddrY,     e_y);
      chk("wdata",      wa.wdata,      e_data);
      cnt_we += int'(wa.we);
      cnt_rd += int'(row_done);
      cnt_fd += int'(frame_done);
   endtask

   task automatic drive_and_clock(input bit fs, input bit v, input bit rel, input logic [31:0] d);
      bit xfer;
      bit last;
      frame_start = fs;
      in_valid    = v;
      row_release = rel;
      in_data     = d;
      xfer = v && m_ready();
      last = xfer && ((m_beats % BLK) == BLK - 1);
      @(posedge clk);
      #1;
      e_we = xfer;
      e_rd = last;
      if (xfer) begin
         e_blk  = m_beats % BLK;
         e_y    = m_rows_total % DEP;
         e_data = d;
      end
      if (fs && !m_busy()) begin
         m_fill  = 1'b1;
         m_beats = 0;
      end else if (xfer) begin
         m_beats++;
         if (last) m_rows_total++;
         if (m_beats == TOTAL) begin
            m_fill      = 1'b0;
            m_drain_end = m_cyc + 3;
         end
      end
      if (last && !rel) m_credits--;
      else if (rel && !last && (m_credits < DEP)) m_credits++;
      m_cyc++;
   endtask

   task automatic step(input bit fs, input bit v, input bit rel, input logic [31:0] d);
      sync_check();
      drive_and_clock(fs, v, rel, d);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst = 1'b1;
      frame_start = 1'b0;
      in_valid    = 1'b0;
      row_release = 1'b0;
      #1;
      chk("rst_in_ready",   in_ready,      0);
      chk("rst_busy",       busy,          0);
      chk("rst_frame_done", frame_done,    0);
      chk("rst_row_done",   row_done,      0);
      chk("rst_we",         wa.we,         0);
      chk("rst_waddrY",     wa.waddrY,     0);
      chk("rst_waddrBlock", wa.waddrBlock, 0);
      chk("rst_wdata",      wa.wdata,      0);
      chk("rst_rows_free",  rows_free,     DEP);
      m_fill = 1'b0; m_beats = 0; m_rows_total = 0; m_credits = DEP; m_drain_end = -100;
      e_we = 1'b0; e_rd = 1'b0; e_y = 0; e_blk = 0; e_data = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      //            fs v rel | we y blk rd fd rdy free bsy
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 4, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 4, 1'b1};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 4, 1'b1};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 1, 1'b0, 1'b0, 1'b1, 4, 1'b1};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 2, 1'b0, 1'b0, 1'b1, 4, 1'b1};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 3, 1'b1, 1'b0, 1'b1, 3, 1'b1};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 3, 1'b0, 1'b0, 1'b1, 3, 1'b1};
      tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1, 0, 1'b0, 1'b0, 1'b1, 4, 1'b1};
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1, 1, 1'b0, 1'b0, 1'b1, 4, 1'b1};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0, 1'b0, 1'b1, 4, 1'b1};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 2, 1'b0, 1'b0, 1'b1, 4, 1'b1};

      do_reset();
      for (int i = 0; i < 11; i++) begin
         sync_check();
         chk($sformatf("tbl%0d_we", i),   wa.we,         tbl[i].we);
         chk($sformatf("tbl%0d_y", i),    wa.waddrY,     tbl[i].y);
         chk($sformatf("tbl%0d_blk", i),  wa.waddrBlock, tbl[i].blk);
         chk($sformatf("tbl%0d_rd", i),   row_done,      tbl[i].rd);
         chk($sformatf("tbl%0d_fd", i),   frame_done,    tbl[i].fd);
         chk($sformatf("tbl%0d_rdy", i),  in_ready,      tbl[i].rdy);
         chk($sformatf("tbl%0d_free", i), rows_free,     tbl[i].free);
         chk($sformatf("tbl%0d_busy", i), busy,          tbl[i].bsy);
         drive_and_clock(tbl[i].fs, tbl[i].v, tbl[i].rel, 32'hA000_0000 + i);
      end

      // Full frame, valid held, one release per finished row, stray frame_start mid-frame.
      do_reset();
      cnt_we = 0; cnt_rd = 0; cnt_fd = 0;
      step(1'b1, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < TOTAL + 8; i++) step(i == 10, 1'b1, e_rd, $urandom);
      chk("frame_writes",     cnt_we, TOTAL);
      chk("frame_row_done",   cnt_rd, ROWS);
      chk("frame_done_count", cnt_fd, 1);

      // Second frame continues from the wrapped row pointer; no releases until stall.
      step(1'b1, 1'b0, 1'b0, 32'h0);
      cnt_we = 0;
      step(1'b0, 1'b1, 1'b0, $urandom);
      chk("frame2_first_y", wa.waddrY, 2);
      for (int i = 0; i < 19; i++) step(1'b0, 1'b1, 1'b0, $urandom);
      chk("stall_ready", in_ready, 0);
      chk("stall_free",  rows_free, 0);
      step(1'b0, 1'b1, 1'b1, $urandom);
      chk("release_ready",       in_ready, 1);
      chk("release_free",        rows_free, 1);
      chk("writes_before_stall", cnt_we, 16);

      // Release coinciding with the last block of a row leaves the credit count alone.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, $urandom);
      step(1'b0, 1'b1, 1'b1, $urandom);
      chk("simul_free",     rows_free, 1);
      chk("simul_row_done", row_done, 1);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, e_rd, $urandom);

      // Reset in the middle of a row, then a clean restart.
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, $urandom);
      step(1'b0, 1'b1, 1'b0, $urandom);
      do_reset();
      step(1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, $urandom);
      chk("restart_y",   wa.waddrY, 0);
      chk("restart_blk", wa.waddrBlock, 0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 32'h0);

      for (int i = 0; i < 3000; i++) begin
         step(($urandom % 12) == 0, ($urandom % 4) != 0, ($urandom % 5) == 0, $urandom);
      end
      sync_check();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
